// File: rtl/arbiter_n_to_1_request.sv
// arbiter_n_to_1_request: round-robin merge of N MemoryPacket streams through per-requester fwft FIFOs.
// Define ARBITER_N_TO_1_BURST_HOLD_EN to hold each grant for up to MAX_BURST consecutive packets.
package arbiter_n_to_1_pkg;
   typedef struct packed {
      logic [3:0] to;
      logic [3:0] from;
   } packet_route_t;
   typedef struct packed {
      packet_route_t route;
      logic [31:0]   address;
   } packet_meta_t;
   typedef struct packed {
      packet_meta_t meta;
      logic [31:0]  data;
   } packet_payload_t;
   typedef struct packed {
      logic            valid;
      packet_payload_t payload;
   } MemoryPacket;
   typedef struct packed {
      logic rd_en;
   } FIFOStateSignalsInput;
   typedef struct packed {
      logic full;
      logic prog_full;
      logic empty;
      logic valid;
      logic rst_busy;
   } FIFOStateSignalsOutput;
endpackage

module arbiter_n_to_1_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int PROG  = DEPTH / 2
) (
   input  logic             ap_clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             prog_full,
   output logic             empty,
   output logic             rst_busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic [1:0]       busy_cnt;
   logic             wr_ok, rd_ok;
   assign rst_busy  = busy_cnt != 2'd0;
   assign full      = count == CW'(DEPTH);
   assign prog_full = count >= CW'(PROG);
   assign empty     = count == '0;
   assign dout      = mem[rd_ptr];
   assign wr_ok     = wr_en && !full && !rst_busy;
   assign rd_ok     = rd_en && !empty && !rst_busy;
   // busy window after reset mimics a vendor FIFO's rst_busy handshake
   always_ff @(posedge ap_clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         busy_cnt <= 2'd3;
      end else begin
         busy_cnt <= rst_busy ? busy_cnt - 2'd1 : busy_cnt;
         wr_ptr   <= wr_ok ? ((wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1)) : wr_ptr;
         rd_ptr   <= rd_ok ? ((rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1)) : rd_ptr;
         count    <= count + CW'(wr_ok) - CW'(rd_ok);
      end
   end
   always_ff @(posedge ap_clk) if (wr_ok) mem[wr_ptr] <= din;
endmodule

module arbiter_n_to_1_request
   import arbiter_n_to_1_pkg::*;
#(
   parameter int NUM_MEMORY_REQUESTOR = 2,
   parameter int FIFO_IN_DEPTH        = 16,
   parameter int FIFO_OUT_DEPTH       = 32,
   parameter int MAX_BURST            = 4
) (
   input  logic                  ap_clk,
   input  logic                  areset,
   input  MemoryPacket           request_in [NUM_MEMORY_REQUESTOR],
   input  FIFOStateSignalsInput  fifo_request_signals_in,
   output FIFOStateSignalsOutput fifo_request_signals_out [NUM_MEMORY_REQUESTOR],
   output MemoryPacket           request_out,
   output logic                  fifo_setup_signal
);
   localparam int N  = NUM_MEMORY_REQUESTOR;
   localparam int PW = $clog2(N);
   localparam int DW = $bits(packet_payload_t);
   typedef enum logic [1:0] {RESET, SETUP, RUN} state_t;

   if (NUM_MEMORY_REQUESTOR < 2 || MAX_BURST < 1) begin : g_bad_cfg
      $error("arbiter_n_to_1_request: NUM_MEMORY_REQUESTOR must be >= 2 and MAX_BURST >= 1");
   end

   logic          areset_ctrl, areset_fifo, rst_c, rst_f;
   state_t        state, state_next;
   MemoryPacket   req_reg [N];
   logic [DW-1:0] in_dout [N];
   logic [N-1:0]  in_wr, in_rd, in_empty, in_full, in_prog, in_busy, elig, grant_reg;
   logic [DW-1:0] grant_data, out_dout;
   logic          out_empty, out_prog, out_full, out_busy, out_rd, out_stall;
   logic          rd_en_reg, grant_any, any_busy;
   logic [PW-1:0] rr_ptr, grant_idx, ptr_next, idx;

   // areset acts on the very next edge and is stretched one cycle by its register copies
   assign rst_c     = areset || areset_ctrl;
   assign rst_f     = areset || areset_fifo;
   assign any_busy  = (|in_busy) || out_busy;
   assign out_stall = out_prog || out_full;
   assign out_rd    = rd_en_reg && !out_empty && !out_busy;

   always_ff @(posedge ap_clk) begin
      areset_ctrl <= areset;
      areset_fifo <= areset;
   end

   always_ff @(posedge ap_clk) state <= rst_c ? RESET : state_next;

   always_comb begin
      state_next = state;
      if (state == RESET) state_next = SETUP;
      else if (state == SETUP && !any_busy) state_next = RUN;
   end

   for (genvar g = 0; g < N; g++) begin : g_in
      assign in_wr[g] = req_reg[g].valid && (|req_reg[g].payload.meta.route.to);
      assign in_rd[g] = grant_any && grant_idx == PW'(g);
      assign elig[g]  = !in_empty[g] && !out_stall && state == RUN;
      arbiter_n_to_1_fifo #(.DEPTH(FIFO_IN_DEPTH), .WIDTH(DW)) u_fifo (
         .ap_clk    (ap_clk),
         .rst       (rst_f),
         .wr_en     (in_wr[g]),
         .din       (req_reg[g].payload),
         .rd_en     (in_rd[g]),
         .dout      (in_dout[g]),
         .full      (in_full[g]),
         .prog_full (in_prog[g]),
         .empty     (in_empty[g]),
         .rst_busy  (in_busy[g])
      );
   end

   always_ff @(posedge ap_clk) begin
      for (int i = 0; i < N; i++) begin
         req_reg[i] <= rst_c ? '0 : request_in[i];
         fifo_request_signals_out[i] <= rst_c
            ? FIFOStateSignalsOutput'{full: 1'b0, prog_full: 1'b0, empty: 1'b1, valid: 1'b0, rst_busy: 1'b1}
            : FIFOStateSignalsOutput'{full: in_full[i], prog_full: in_prog[i], empty: in_empty[i],
                                      valid: !in_empty[i], rst_busy: in_busy[i]};
      end
   end

   // descending scan so the lowest cyclic offset from rr_ptr wins
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = PW'((int'(rr_ptr) + k) % N);
         if (elig[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
         end
      end
   end

   assign ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);

`ifdef ARBITER_N_TO_1_BURST_HOLD_EN
   localparam int BW = $clog2(MAX_BURST + 1);
   logic [BW-1:0] burst_cnt, burst_next;
   // rr_ptr parks on the holder during a burst; a grant elsewhere or an idle cycle ends it
   assign burst_next = (grant_idx == rr_ptr && burst_cnt != '0) ? burst_cnt + BW'(1) : BW'(1);
   always_ff @(posedge ap_clk) begin
      if (rst_c) begin
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else if (grant_any) begin
         burst_cnt <= (burst_next == BW'(MAX_BURST)) ? '0 : burst_next;
         rr_ptr    <= (burst_next == BW'(MAX_BURST)) ? ptr_next : grant_idx;
      end else if (burst_cnt != '0) begin
         burst_cnt <= '0;
         rr_ptr    <= (rr_ptr == PW'(N - 1)) ? '0 : rr_ptr + PW'(1);
      end
   end
`else
   always_ff @(posedge ap_clk) rr_ptr <= rst_c ? '0 : grant_any ? ptr_next : rr_ptr;
`endif

   always_ff @(posedge ap_clk) begin
      grant_reg           <= (rst_c || !grant_any) ? '0 : N'(1) << grant_idx;
      grant_data          <= in_dout[grant_idx];
      rd_en_reg           <= !rst_c && fifo_request_signals_in.rd_en;
      request_out.valid   <= !rst_c && out_rd;
      request_out.payload <= out_dout;
      fifo_setup_signal   <= rst_c || any_busy;
   end

   arbiter_n_to_1_fifo #(.DEPTH(FIFO_OUT_DEPTH), .WIDTH(DW)) u_out_fifo (
      .ap_clk    (ap_clk),
      .rst       (rst_f),
      .wr_en     (|grant_reg),
      .din       (grant_data),
      .rd_en     (out_rd),
      .dout      (out_dout),
      .full      (out_full),
      .prog_full (out_prog),
      .empty     (out_empty),
      .rst_busy  (out_busy)
   );
endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// tb_arbiter_n_to_1_request: directed bench for the 4-requester round-robin merger.
module tb_arbiter_n_to_1_request;
   import arbiter_n_to_1_pkg::*;
   localparam int N = 4;

   logic                  ap_clk = 1'b0;
   logic                  areset = 1'b1;
   MemoryPacket           request_in [N];
   FIFOStateSignalsInput  fifo_request_signals_in;
   FIFOStateSignalsOutput fifo_request_signals_out [N];
   MemoryPacket           request_out;
   logic                  fifo_setup_signal;

   int              n_pass = 0;
   int              n_total = 0;
   int              cyc = 0;
   int              t0;
   packet_payload_t out_q[$];
   int              out_cyc[$];

   arbiter_n_to_1_request #(.NUM_MEMORY_REQUESTOR(N)) dut (
      .ap_clk                   (ap_clk),
      .areset                   (areset),
      .request_in               (request_in),
      .fifo_request_signals_in  (fifo_request_signals_in),
      .fifo_request_signals_out (fifo_request_signals_out),
      .request_out              (request_out),
      .fifo_setup_signal        (fifo_setup_signal)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) cyc <= cyc + 1;

   always @(posedge ap_clk) begin
      #1;
      if (request_out.valid === 1'b1) begin
         out_q.push_back(request_out.payload);
         out_cyc.push_back(cyc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_pkt(input string tag, input int k, input int src, input int seq);
      check($sformatf("%s[%0d]", tag, k), 64'(out_q[k].data), 64'({8'(src), 24'(seq)}));
   endtask

   function automatic MemoryPacket mk(input int src, input int seq, input logic [3:0] to);
      MemoryPacket p;
      p.valid                   = 1'b1;
      p.payload.meta.route.to   = to;
      p.payload.meta.route.from = 4'(src);
      p.payload.meta.address    = 32'(seq);
      p.payload.data            = {8'(src), 24'(seq)};
      return p;
   endfunction

   task automatic idle_all();
      for (int i = 0; i < N; i++) request_in[i] = '0;
   endtask

   task automatic wait_setup(input string tag);
      int c = 0;
      while (fifo_setup_signal !== 1'b0 && c < 50) begin
         @(negedge ap_clk);
         c++;
      end
      check(tag, 64'(fifo_setup_signal), 64'(0));
      repeat (2) @(negedge ap_clk);
   endtask

   task automatic wait_out(input int n, input int budget);
      int c = 0;
      while (out_q.size() < n && c < budget) begin
         @(negedge ap_clk);
         c++;
      end
   endtask

   initial begin
      fifo_request_signals_in.rd_en = 1'b1;
      idle_all();
      // reset state
      repeat (4) @(negedge ap_clk);
      check("rst_valid", 64'(request_out.valid), 64'(0));
      check("rst_setup", 64'(fifo_setup_signal), 64'(1));
      check("rst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
      check("rst_grant_reg", 64'(dut.grant_reg), 64'(0));
      areset = 1'b0;
      wait_setup("setup_done");
      repeat (10) @(negedge ap_clk);
      check("idle_no_output", 64'(out_q.size()), 64'(0));

      // single requester, 8 packets, latency 5
      t0 = cyc;
      for (int s = 0; s < 8; s++) begin
         request_in[1] = mk(1, s, 4'd1);
         @(negedge ap_clk);
      end
      idle_all();
      wait_out(8, 40);
      repeat (5) @(negedge ap_clk);
      check("single_count", 64'(out_q.size()), 64'(8));
      check("single_latency", 64'(out_cyc[0] - t0), 64'(5));
      for (int k = 0; k < 8; k++) check_pkt("single_pkt", k, 1, k);

      // all four loaded: rr_ptr sits at 2 after grants to requester 1
      check("rr_before_all", 64'(dut.rr_ptr), 64'(2));
      out_q.delete();
      out_cyc.delete();
      for (int s = 0; s < 6; s++) begin
         for (int g = 0; g < N; g++) request_in[g] = mk(g, s, 4'd1);
         @(negedge ap_clk);
      end
      idle_all();
      wait_out(24, 60);
      repeat (5) @(negedge ap_clk);
      check("rr_count", 64'(out_q.size()), 64'(24));
      for (int k = 0; k < 24; k++) check_pkt("rr_pkt", k, (2 + k) % 4, k / 4);

      // backpressure: 40 packets with rd_en low
      out_q.delete();
      out_cyc.delete();
      fifo_request_signals_in.rd_en = 1'b0;
      for (int s = 0; s < 20; s++) begin
         request_in[0] = mk(0, s, 4'd1);
         request_in[1] = mk(1, s, 4'd1);
         @(negedge ap_clk);
      end
      idle_all();
      repeat (10) @(negedge ap_clk);
      check("bp_no_output", 64'(out_q.size()), 64'(0));
      check("bp_out_level", 64'(dut.u_out_fifo.count), 64'(17));
      check("bp_in0_prog_full", 64'(fifo_request_signals_out[0].prog_full), 64'(1));
      check("bp_in0_full", 64'(fifo_request_signals_out[0].full), 64'(0));
      check("bp_in1_prog_full", 64'(fifo_request_signals_out[1].prog_full), 64'(1));
      check("bp_in1_full", 64'(fifo_request_signals_out[1].full), 64'(0));
      fifo_request_signals_in.rd_en = 1'b1;
      wait_out(40, 200);
      repeat (10) @(negedge ap_clk);
      check("bp_drain_count", 64'(out_q.size()), 64'(40));
      for (int k = 0; k < 40; k++) check_pkt("bp_pkt", k, k % 2, k / 2);

      // route.to == 0 is dropped
      out_q.delete();
      out_cyc.delete();
      request_in[0] = mk(0, 'h50, 4'd1);
      @(negedge ap_clk);
      request_in[0] = mk(0, 'h51, 4'd0);
      @(negedge ap_clk);
      request_in[0] = mk(0, 'h52, 4'd1);
      @(negedge ap_clk);
      idle_all();
      repeat (20) @(negedge ap_clk);
      check("drop_count", 64'(out_q.size()), 64'(2));
      check_pkt("drop_pkt", 0, 0, 'h50);
      check_pkt("drop_pkt", 1, 0, 'h52);

      // reset mid-stream
      out_q.delete();
      out_cyc.delete();
      for (int s = 0; s < 6; s++) begin
         request_in[2] = mk(2, s, 4'd1);
         @(negedge ap_clk);
      end
      idle_all();
      areset = 1'b1;
      @(negedge ap_clk);
      check("midrst_valid", 64'(request_out.valid), 64'(0));
      check("midrst_rr_ptr", 64'(dut.rr_ptr), 64'(0));
      check("midrst_grant_reg", 64'(dut.grant_reg), 64'(0));
      areset = 1'b0;
      out_q.delete();
      out_cyc.delete();
      @(negedge ap_clk);
      check("midrst_valid_next", 64'(request_out.valid), 64'(0));
      wait_setup("midrst_setup_done");
      repeat (30) @(negedge ap_clk);
      check("midrst_no_stale", 64'(out_q.size()), 64'(0));
      check("midrst_rr_idle", 64'(dut.rr_ptr), 64'(0));
      t0 = cyc;
      request_in[3] = mk(3, 'h77, 4'd1);
      @(negedge ap_clk);
      idle_all();
      wait_out(1, 20);
      repeat (5) @(negedge ap_clk);
      check("post_rst_count", 64'(out_q.size()), 64'(1));
      check_pkt("post_rst_pkt", 0, 3, 'h77);
      check("post_rst_latency", 64'(out_cyc[0] - t0), 64'(5));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
